ram_hs_param: RTL and testbench

//  Parametrised byte-addressed, big-endian data/instruction memory with MOV/MOC handshake
//  and programmable wait states. Serves the DataPath control unit's memory cycles.

---
 rtl/ram_hs_param_if.sv | 25 ++
 rtl/ram_hs_param.sv | 140 ++++++++++++++
 tb/tb_ram_hs_param.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_hs_param_if.sv
// Request/response bundle between the control unit and the byte-addressed memory.
interface ram_hs_param_if #(
  parameter int ADDR_W = 9
);
  logic              MOV;
  logic              RW;
  logic [ADDR_W-1:0] Address;
  logic [1:0]        Size;
  logic              Signed;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              Busy;
  logic              Err;

  modport master (
    output MOV, RW, Address, Size, Signed, DataIn,
    input  DataOut, MOC, Busy, Err
  );

  modport slave (
    input  MOV, RW, Address, Size, Signed, DataIn,
    output DataOut, MOC, Busy, Err
  );
endinterface

// File: rtl/ram_hs_param.sv
// Big-endian byte memory with MOV/MOC handshake, programmable wait states,
// byte/half/word access with load extension and misalignment reporting.
module ram_hs_param #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  ram_hs_param_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [7:0]        mem [DEPTH];

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q;
  logic              moc_q;
  logic              err_q;

  logic [ADDR_W-1:0] lane_addr [4];
  logic [7:0]        lane_rd   [4];
  logic [7:0]        lane_wr   [4];
  logic [3:0]        lane_en;
  logic [31:0]       din_aligned_d;
  logic [31:0]       rd_data_d;
  logic              access;
  logic              wr_en;

  function automatic logic is_illegal(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
    return (sz == 2'b11) ||
           (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Left-justify the write data so lane 0 (lowest address) always takes the top byte.
  always_comb begin
    din_aligned_d = din_q;
    case (size_q)
      2'b00:   din_aligned_d = {din_q[7:0], 24'h0};
      2'b01:   din_aligned_d = {din_q[15:0], 16'h0};
      default: din_aligned_d = din_q;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi] = addr_q + ADDR_W'(gi);
    assign lane_rd[gi]   = mem[lane_addr[gi]];
    assign lane_wr[gi]   = din_aligned_d[8*(3-gi) +: 8];
    assign lane_en[gi]   = (gi == 0) || (size_q == 2'b10) || (size_q == 2'b01 && gi < 2);
  end

  always_comb begin
    rd_data_d = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    case (size_q)
      2'b00:   rd_data_d = {{24{sgn_q & lane_rd[0][7]}}, lane_rd[0]};
      2'b01:   rd_data_d = {{16{sgn_q & lane_rd[0][7]}}, lane_rd[0], lane_rd[1]};
      default: rd_data_d = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    endcase
  end

  assign access = (state_q == BUSY) && (cnt_q == 4'd0);
  assign wr_en  = access && !rw_q;

  // Contents survive reset; a write only lands on the access edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (lane_en[0]) mem[lane_addr[0]] <= lane_wr[0];
      if (lane_en[1]) mem[lane_addr[1]] <= lane_wr[1];
      if (lane_en[2]) mem[lane_addr[2]] <= lane_wr[2];
      if (lane_en[3]) mem[lane_addr[3]] <= lane_wr[3];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      din_q   <= 32'h0;
      dout_q  <= 32'h0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.MOV) begin
            addr_q <= bus.Address;
            rw_q   <= bus.RW;
            size_q <= bus.Size;
            sgn_q  <= bus.Signed;
            din_q  <= bus.DataIn;
            if (is_illegal(bus.Size, bus.Address)) begin
              state_q <= DONE;
              moc_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (rw_q) dout_q <= rd_data_d;
            moc_q   <= 1'b1;
            err_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!bus.MOV) begin
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc_q;
  assign bus.Err     = err_q;
  assign bus.Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ram_hs_param.sv
// Self-checking bench for ram_hs_param: directed table, handshake corner cases,
// a zero-wait-state instance and randomized traffic against a byte-array model.
module tb_ram_hs_param;
  localparam int WAITC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_hs_param_if #(.ADDR_W(9)) bus  ();
  ram_hs_param_if #(.ADDR_W(9)) bus0 ();

  ram_hs_param #(.ADDR_W(9), .WAIT_CYCLES(WAITC)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  ram_hs_param #(.ADDR_W(9), .WAIT_CYCLES(0))     dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  int nvec = 0;
  int nmis = 0;

  logic [7:0]  mm [512];
  logic [31:0] mdout = 32'h0;

  typedef struct {
    logic        rw;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] din;
    logic [31:0] dout;
    logic        err;
    int          lat;
    logic        chk_dout;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic rw, logic [8:0] a, logic [1:0] sz, logic sg,
                              logic [31:0] din, logic [31:0] dout, logic err, logic cd);
    vec_t v;
    v.rw = rw; v.addr = a; v.size = sz; v.sgn = sg; v.din = din;
    v.dout = dout; v.err = err; v.lat = err ? 0 : WAITC + 1; v.chk_dout = cd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: applies the access rules directly to a byte array.
  task automatic model_op(input logic rw, input logic [8:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] din, input int wc,
                          output int elat, output logic eerr, output logic [31:0] edout);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (int'(a) % n) != 0) begin
      eerr = 1'b1;
      elat = 0;
    end else begin
      eerr = 1'b0;
      elat = wc + 1;
      if (!rw) begin
        for (int i = 0; i < n; i++) mm[int'(a) + i] = 8'(din >> (8 * (n - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mm[int'(a) + i]);
        if (n < 4 && sg && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        mdout = v;
      end
    end
    edout = mdout;
  endtask

  task automatic set_req(input logic rw, input logic [8:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] din);
    bus.RW = rw;  bus.Address = a;  bus.Size = sz;  bus.Signed = sg;  bus.DataIn = din;
    bus0.RW = rw; bus0.Address = a; bus0.Size = sz; bus0.Signed = sg; bus0.DataIn = din;
  endtask

  // Called just after a rising edge; lat counts edges after the accepting edge E0.
  task automatic do_op(input bit sel, input logic rw, input logic [8:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] din,
                       output int lat, output logic err, output logic [31:0] dout);
    logic m;
    set_req(rw, a, sz, sg, din);
    if (sel) bus0.MOV = 1'b1; else bus.MOV = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      m = sel ? bus0.MOC : bus.MOC;
      if (m) break;
    end
    err  = sel ? bus0.Err : bus.Err;
    dout = sel ? bus0.DataOut : bus.DataOut;
    @(posedge clk); #1;
    chk("moc_held",  sel ? bus0.MOC  : bus.MOC,  1);
    chk("busy_done", sel ? bus0.Busy : bus.Busy, 1);
    bus.MOV = 1'b0; bus0.MOV = 1'b0;
    @(posedge clk); #1;
    chk("moc_clear",  sel ? bus0.MOC  : bus.MOC,  0);
    chk("err_clear",  sel ? bus0.Err  : bus.Err,  0);
    chk("busy_clear", sel ? bus0.Busy : bus.Busy, 0);
  endtask

  task automatic model_checked_op(input logic rw, input logic [8:0] a, input logic [1:0] sz,
                                  input logic sg, input logic [31:0] din);
    int lat, elat;
    logic err, eerr;
    logic [31:0] dout, edout;
    model_op(rw, a, sz, sg, din, WAITC, elat, eerr, edout);
    do_op(0, rw, a, sz, sg, din, lat, err, dout);
    chk("lat",  32'(lat), 32'(elat));
    chk("err",  err, eerr);
    chk("dout", dout, edout);
  endtask

  initial begin
    int lat, n, elat;
    logic err, eerr;
    logic [31:0] dout, edout;
    logic [8:0] a;
    logic [1:0] sz;
    int r;

    // Reset held with a pending request.
    reset = 1'b0;
    bus.MOV = 1'b1; bus0.MOV = 1'b1;
    set_req(1'b0, 9'h000, 2'b10, 1'b0, 32'h12345678);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_moc",   bus.MOC, 0);
    chk("rst_busy",  bus.Busy, 0);
    chk("rst_err",   bus.Err, 0);
    chk("rst_dout",  bus.DataOut, 32'h0);
    chk("rst0_dout", bus0.DataOut, 32'h0);
    chk("rst0_moc",  bus0.MOC, 0);
    bus.MOV = 1'b0; bus0.MOV = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill the whole memory so every later read has a known value.
    for (int w = 0; w < 128; w++) model_checked_op(1'b0, 9'(w * 4), 2'b10, 1'b0, $urandom);

    tbl[0]  = mk(0, 9'h010, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 0);
    tbl[1]  = mk(1, 9'h010, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0, 1);
    tbl[2]  = mk(0, 9'h005, 2'b00, 0, 32'hFFFFFF80, 32'hDEADBEEF, 0, 1);
    tbl[3]  = mk(1, 9'h005, 2'b00, 1, 32'h0,        32'hFFFFFF80, 0, 1);
    tbl[4]  = mk(1, 9'h005, 2'b00, 0, 32'h0,        32'h00000080, 0, 1);
    tbl[5]  = mk(0, 9'h004, 2'b00, 0, 32'h00000012, 32'h00000080, 0, 1);
    tbl[6]  = mk(1, 9'h004, 2'b01, 1, 32'h0,        32'h00001280, 0, 1);
    tbl[7]  = mk(1, 9'h010, 2'b01, 0, 32'h0,        32'h0000DEAD, 0, 1);
    tbl[8]  = mk(1, 9'h012, 2'b01, 1, 32'h0,        32'hFFFFBEEF, 0, 1);
    tbl[9]  = mk(1, 9'h011, 2'b01, 0, 32'h0,        32'hFFFFBEEF, 1, 1);
    tbl[10] = mk(1, 9'h000, 2'b11, 0, 32'h0,        32'hFFFFBEEF, 1, 1);
    tbl[11] = mk(0, 9'h002, 2'b10, 0, 32'h55555555, 32'hFFFFBEEF, 1, 1);
    tbl[12] = mk(0, 9'h1FC, 2'b10, 0, 32'hA5A5A5A5, 32'hFFFFBEEF, 0, 1);
    tbl[13] = mk(1, 9'h1FC, 2'b10, 1, 32'h0,        32'hA5A5A5A5, 0, 1);
    tbl[14] = mk(1, 9'h1FF, 2'b00, 0, 32'h0,        32'h000000A5, 0, 1);
    tbl[15] = mk(1, 9'h013, 2'b00, 1, 32'h0,        32'hFFFFFFEF, 0, 1);

    for (int i = 0; i < 16; i++) begin
      model_op(tbl[i].rw, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].din, WAITC, elat, eerr, edout);
      do_op(0, tbl[i].rw, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].din, lat, err, dout);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
      if (tbl[i].chk_dout) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
    end
    chk("mem_010", 32'(dut.mem[9'h010]), 32'hDE);
    chk("mem_013", 32'(dut.mem[9'h013]), 32'hEF);
    chk("mem_1ff", 32'(dut.mem[9'h1FF]), 32'hA5);
    chk("mem_002", 32'(dut.mem[9'h002]), 32'(mm[2]));

    // Reset pulse one edge into a write: the write is lost.
    set_req(1'b0, 9'h020, 2'b10, 1'b0, 32'h11223344);
    bus.MOV = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", bus.Busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_moc_async",  bus.MOC, 0);
    chk("abort_busy_async", bus.Busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.MOV = 1'b0;
    mdout = 32'h0;
    @(posedge clk); #1;
    chk("abort_dout", bus.DataOut, 32'h0);
    chk("abort_idle", bus.Busy, 0);
    model_checked_op(1'b1, 9'h020, 2'b10, 1'b0, 32'h0);

    // MOV dropped during BUSY: MOC still rises, for exactly one cycle.
    model_op(1'b1, 9'h010, 2'b10, 1'b0, 32'h0, WAITC, elat, eerr, edout);
    set_req(1'b1, 9'h010, 2'b10, 1'b0, 32'h0);
    bus.MOV = 1'b1;
    @(posedge clk); #1;
    bus.MOV = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      if (bus.MOC) break;
    end
    chk("drop_lat",  32'(n), 32'(WAITC + 1));
    chk("drop_dout", bus.DataOut, edout);
    @(posedge clk); #1;
    chk("drop_moc_pulse", bus.MOC, 0);
    chk("drop_idle", bus.Busy, 0);

    // Zero wait states.
    do_op(1, 1'b0, 9'h040, 2'b10, 1'b0, 32'h0BADF00D, lat, err, dout);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    chk("w0_wr_err", err, 0);
    do_op(1, 1'b1, 9'h040, 2'b10, 1'b0, 32'h0, lat, err, dout);
    chk("w0_rd_lat",  32'(lat), 32'd1);
    chk("w0_rd_dout", dout, 32'h0BADF00D);
    do_op(1, 1'b1, 9'h041, 2'b00, 1'b1, 32'h0, lat, err, dout);
    chk("w0_rdb_dout", dout, 32'hFFFFFFAD);
    do_op(1, 1'b1, 9'h042, 2'b10, 1'b0, 32'h0, lat, err, dout);
    chk("w0_mis_lat",  32'(lat), 32'd0);
    chk("w0_mis_err",  err, 1);
    chk("w0_mis_dout", dout, 32'hFFFFFFAD);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      model_checked_op(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
